// File: rtl/axi_tmp_pkg.sv
// axi_tmp_pkg: shared response codes, register count and FSM state types
package axi_tmp_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int REG_COUNT = 4;
  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_tmp_strb_merge.sv
// axi_tmp_strb_merge: byte-lane merge of a new word over an old word
module axi_tmp_strb_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   old_word,
  input  logic [WIDTH-1:0]   new_word,
  input  logic [WIDTH/8-1:0] strb,
  output logic [WIDTH-1:0]   merged
);
  for (genvar b = 0; b < WIDTH / 8; b++) begin : g_lane
    assign merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/axi_tmp_lite_slave.sv
// axi_tmp_lite_slave: AXI4-Lite slave with four 32-bit registers
module axi_tmp_lite_slave
  import axi_tmp_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                                    ACLK,
  input  logic                                    ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                              S_AXI_AWPROT,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                              S_AXI_ARPROT,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [REG_COUNT*C_S_AXI_DATA_WIDTH-1:0] regs_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DW-1:0] regs [REG_COUNT];
  logic [AW-1:0] awaddr_q, wr_addr;
  logic [DW-1:0] wdata_q, wr_data, merged;
  logic [DW/8-1:0] wstrb_q, wr_strb;
  logic aw_hs, w_hs, ar_hs, wr_en, wr_unmapped, rd_unmapped;
  logic [1:0] wr_idx, rd_idx;
  logic unused_ok;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  // The second half of a split write may arrive this cycle, so use it directly
  assign wr_addr = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_en = (w_next == W_RESP) && (w_state != W_RESP);
  assign wr_idx = wr_addr[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign wr_unmapped = |wr_addr[AW-1:4];
  assign rd_unmapped = |S_AXI_ARADDR[AW-1:4];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};
  axi_tmp_strb_merge #(.WIDTH(DW)) u_merge (
    .old_word(regs[wr_idx]),
    .new_word(wr_data),
    .strb    (wr_strb),
    .merged  (merged)
  );
  always_ff @(posedge ACLK) begin
    w_state <= ARESET ? W_IDLE : w_next;
    r_state <= ARESET ? R_IDLE : r_next;
  end
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_GOT_A : w_hs ? W_GOT_D : W_IDLE;
      W_GOT_A: w_next = w_hs ? W_RESP : W_GOT_A;
      W_GOT_D: w_next = aw_hs ? W_RESP : W_GOT_D;
      default: w_next = S_AXI_BREADY ? W_IDLE : W_RESP;
    endcase
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
  end
  always_comb begin
    S_AXI_AWREADY = !ARESET && (w_state == W_IDLE || w_state == W_GOT_D);
    S_AXI_WREADY = !ARESET && (w_state == W_IDLE || w_state == W_GOT_A);
    S_AXI_BVALID = w_state == W_RESP;
    S_AXI_ARREADY = !ARESET && r_state == R_IDLE;
    S_AXI_RVALID = r_state == R_DATA;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_en) begin
        S_AXI_BRESP <= wr_unmapped ? RESP_SLVERR : RESP_OKAY;
        if (!wr_unmapped) regs[wr_idx] <= merged;
      end
      if (ar_hs) begin
        S_AXI_RDATA <= rd_unmapped ? '0 : regs[rd_idx];
        S_AXI_RRESP <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs
    assign regs_o[g*DW +: DW] = regs[g];
  end
endmodule

// File: tb/tb_axi_tmp_lite_slave.sv
// tb_axi_tmp_lite_slave: directed stimulus with queued expected B/R responses
module tb_axi_tmp_lite_slave;
  logic ACLK = 0, ARESET = 1;
  logic [4:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [2:0] S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
  logic S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_ARVALID = 0;
  logic S_AXI_BREADY = 1, S_AXI_RREADY = 1;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0] S_AXI_WSTRB = '0;
  logic S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;
  logic [127:0] regs_o;
  int n_chk = 0, n_fail = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  axi_tmp_lite_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // Monitor: a handshake seen at the falling edge completes on the next rising edge
  always @(negedge ACLK) begin
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", S_AXI_BVALID, 0);
      else chk("bresp", S_AXI_BRESP, bq.pop_front());
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (rq.size() == 0) chk("r_unexpected", S_AXI_RVALID, 0);
      else chk("rdata_rresp", {S_AXI_RDATA, S_AXI_RRESP}, rq.pop_front());
    end
  end
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    int cnt;
    logic aw_d, w_d;
    cnt = 0;
    bq.push_back(er);
    S_AXI_AWADDR = a;
    S_AXI_WDATA = d;
    S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1;
    S_AXI_WVALID = 1;
    while ((S_AXI_AWVALID || S_AXI_WVALID) && cnt < 20) begin
      @(negedge ACLK);
      aw_d = S_AXI_AWVALID && S_AXI_AWREADY;
      w_d = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      #1;
      if (aw_d) S_AXI_AWVALID = 0;
      if (w_d) S_AXI_WVALID = 0;
      cnt++;
    end
    chk("wr_accept", {S_AXI_AWVALID, S_AXI_WVALID}, 0);
    S_AXI_AWVALID = 0;
    S_AXI_WVALID = 0;
  endtask
  task automatic do_read(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    int cnt;
    logic ar_d;
    cnt = 0;
    rq.push_back({ed, er});
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1;
    while (S_AXI_ARVALID && cnt < 20) begin
      @(negedge ACLK);
      ar_d = S_AXI_ARREADY;
      @(posedge ACLK);
      #1;
      if (ar_d) S_AXI_ARVALID = 0;
      cnt++;
    end
    chk("rd_accept", S_AXI_ARVALID, 0);
    S_AXI_ARVALID = 0;
    @(negedge ACLK);
    chk("rd_latency", S_AXI_RVALID, 1);
    @(posedge ACLK);
    #1;
  endtask
  task automatic wait_b();
    int cnt;
    cnt = 0;
    while (bq.size() != 0 && cnt < 20) begin
      @(posedge ACLK);
      cnt++;
    end
    #1;
    chk("b_drain", bq.size(), 0);
  endtask
  task automatic wait_r();
    int cnt;
    cnt = 0;
    while (rq.size() != 0 && cnt < 20) begin
      @(posedge ACLK);
      cnt++;
    end
    #1;
    chk("r_drain", rq.size(), 0);
  endtask
  initial begin
    repeat (2) @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    chk("rst_resp_rdata", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 0);
    chk("rst_regs", regs_o, 0);
    @(posedge ACLK);
    #1;
    ARESET = 0;
    @(negedge ACLK);
    chk("post_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    @(posedge ACLK);
    #1;
    // Basic write/readback of all four registers
    for (int i = 0; i < 4; i++) begin
      do_write(5'(4 * i), 32'(i + 1), 4'hF, 2'b00);
      wait_b();
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), 32'(i + 1), 2'b00);
      wait_r();
    end
    chk("regs_1234", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
    // Data ahead of address
    bq.push_back(2'b00);
    S_AXI_WDATA = 32'hA5A5A5A5;
    S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1;
    @(negedge ACLK);
    chk("wfirst_wready", S_AXI_WREADY, 1);
    @(posedge ACLK);
    #1;
    S_AXI_WVALID = 0;
    repeat (2) begin
      @(negedge ACLK);
      chk("got_d_wready", S_AXI_WREADY, 0);
      chk("got_d_bvalid", S_AXI_BVALID, 0);
      @(posedge ACLK);
      #1;
    end
    S_AXI_AWADDR = 5'h08;
    S_AXI_AWVALID = 1;
    @(negedge ACLK);
    chk("got_d_awready", S_AXI_AWREADY, 1);
    chk("got_d_bvalid_pre", S_AXI_BVALID, 0);
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 0;
    @(negedge ACLK);
    chk("got_d_bvalid_post", S_AXI_BVALID, 1);
    @(posedge ACLK);
    wait_b();
    // Address ahead of data
    bq.push_back(2'b00);
    S_AXI_AWADDR = 5'h0C;
    S_AXI_AWVALID = 1;
    @(negedge ACLK);
    chk("afirst_awready", S_AXI_AWREADY, 1);
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 0;
    repeat (2) begin
      @(negedge ACLK);
      chk("got_a_awready", S_AXI_AWREADY, 0);
      chk("got_a_bvalid", S_AXI_BVALID, 0);
      @(posedge ACLK);
      #1;
    end
    S_AXI_WDATA = 32'h5A5A5A5A;
    S_AXI_WVALID = 1;
    @(negedge ACLK);
    chk("got_a_wready", S_AXI_WREADY, 1);
    @(posedge ACLK);
    #1;
    S_AXI_WVALID = 0;
    @(negedge ACLK);
    chk("got_a_bvalid_post", S_AXI_BVALID, 1);
    @(posedge ACLK);
    wait_b();
    chk("regs_split", regs_o, {32'h5A5A5A5A, 32'hA5A5A5A5, 32'd2, 32'd1});
    // Byte strobes; low address bits ignored
    do_write(5'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
    wait_b();
    do_write(5'h07, 32'h12345678, 4'b0101, 2'b00);
    wait_b();
    do_read(5'h04, 32'hFF34FF78, 2'b00);
    wait_r();
    do_write(5'h04, 32'h00000000, 4'h0, 2'b00);
    wait_b();
    do_read(5'h05, 32'hFF34FF78, 2'b00);
    wait_r();
    // Unmapped accesses
    do_write(5'h14, 32'h0000DEAD, 4'hF, 2'b10);
    wait_b();
    do_read(5'h18, 32'h0, 2'b10);
    wait_r();
    chk("regs_unmapped", regs_o, {32'h5A5A5A5A, 32'hA5A5A5A5, 32'hFF34FF78, 32'd1});
    // Back-pressure on B
    S_AXI_BREADY = 0;
    do_write(5'h00, 32'h11, 4'hF, 2'b00);
    repeat (5) begin
      @(negedge ACLK);
      chk("bstall_bvalid", S_AXI_BVALID, 1);
      chk("bstall_bresp", S_AXI_BRESP, 2'b00);
      chk("bstall_readys", {S_AXI_AWREADY, S_AXI_WREADY}, 0);
    end
    @(posedge ACLK);
    #1;
    S_AXI_BREADY = 1;
    wait_b();
    // Back-pressure on R
    S_AXI_RREADY = 0;
    do_read(5'h00, 32'h11, 2'b00);
    repeat (5) begin
      @(negedge ACLK);
      chk("rstall_rvalid", S_AXI_RVALID, 1);
      chk("rstall_rdata", S_AXI_RDATA, 32'h11);
      chk("rstall_arready", S_AXI_ARREADY, 0);
    end
    @(posedge ACLK);
    #1;
    S_AXI_RREADY = 1;
    wait_r();
    // Read captured alongside a write to the same register sees the old value
    fork
      do_write(5'h00, 32'h22, 4'hF, 2'b00);
      do_read(5'h00, 32'h11, 2'b00);
    join
    wait_b();
    wait_r();
    do_read(5'h00, 32'h22, 2'b00);
    wait_r();
    // Reset while holding only an address
    S_AXI_AWADDR = 5'h08;
    S_AXI_AWVALID = 1;
    @(negedge ACLK);
    chk("abort_awready", S_AXI_AWREADY, 1);
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 0;
    ARESET = 1;
    @(negedge ACLK);
    chk("abort_rst_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    chk("abort_regs", regs_o, 0);
    chk("abort_bvalid", S_AXI_BVALID, 0);
    @(posedge ACLK);
    #1;
    ARESET = 0;
    repeat (3) begin
      @(negedge ACLK);
      chk("abort_no_b", S_AXI_BVALID, 0);
    end
    chk("abort_readys_back", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    @(posedge ACLK);
    #1;
    do_write(5'h0C, 32'h77, 4'hF, 2'b00);
    wait_b();
    chk("after_abort_regs", regs_o, {32'h77, 96'h0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_tmp_lite_slave.md
AXI_TMP_LITE_SLAVE -- requirements
Module: axi_tmp_lite_slave

Interface
REQ-001 C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, default 5, byte address width; regs 0x00-0x0C, 0x10-0x1F unmapped.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 S_AXI_AWADDR  in  5  write address.
REQ-006 S_AXI_AWPROT  in  3  accepted, ignored.
REQ-007 S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  AW handshake.
REQ-008 S_AXI_WDATA  in  32  write data.
REQ-009 S_AXI_WSTRB  in  4  byte enables.
REQ-010 S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  W handshake.
REQ-011 S_AXI_BRESP  out  2  write response.
REQ-012 S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  B handshake.
REQ-013 S_AXI_ARADDR  in  5  read address.
REQ-014 S_AXI_ARPROT  in  3  accepted, ignored.
REQ-015 S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  AR handshake.
REQ-016 S_AXI_RDATA  out  32  read data.
REQ-017 S_AXI_RRESP  out  2  read response.
REQ-018 S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  R handshake.
REQ-019 regs_o  out  128  reg3..reg0 concatenated, reg0 in [31:0].

Function
REQ-020 Write FSM SHALL have states W_IDLE, W_GOT_A, W_GOT_D, W_RESP.
REQ-021 AWREADY SHALL be 1 in W_IDLE and W_GOT_D only; WREADY 1 in W_IDLE and W_GOT_A only; neither depends combinationally on VALID.
REQ-022 W_IDLE: AW and W same cycle -> W_RESP; AW only -> W_GOT_A; W only -> W_GOT_D; address/data/strobe latched on their handshake.
REQ-023 W_GOT_A on W handshake, or W_GOT_D on AW handshake -> W_RESP.
REQ-024 Register update SHALL occur on the cycle entering W_RESP, byte lane n written only when WSTRB[n]=1; WSTRB=0 writes nothing but still responds OKAY.
REQ-025 BVALID SHALL be 1 exactly in W_RESP; BVALID&BREADY -> W_IDLE; BVALID held stable with BRESP until accepted.
REQ-026 BRESP SHALL be 2'b00 for addr < 0x10, 2'b10 (SLVERR) otherwise; unmapped writes change no register.
REQ-027 Address bits [1:0] SHALL be ignored (word index = addr[3:2]).
REQ-028 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-029 AR handshake -> R_DATA next cycle with RDATA/RRESP registered; RVALID=1 exactly in R_DATA; RVALID&RREADY -> R_IDLE; RDATA stable until accepted.
REQ-030 Read latency SHALL be 1 cycle from AR handshake to RVALID; back-to-back reads SHALL sustain one per 2 cycles.
REQ-031 Unmapped read SHALL return RDATA=0, RRESP=2'b10.
REQ-032 Read and write FSMs SHALL run independently; a read captured in the cycle a write updates the same register SHALL return the pre-write value.
REQ-033 Write throughput SHALL be one per 2 cycles minimum (W_IDLE -> W_RESP -> W_IDLE with BREADY=1).

Reset
REQ-034 With ARESET=1 at a clock edge: both FSMs to IDLE, reg0-reg3=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0 during reset.
REQ-035 Reset mid-transaction SHALL abandon it silently (no B/R issued); READYs rise the first cycle after ARESET deasserts.

Structure
REQ-036 Shared package axi_tmp_pkg SHALL hold resp constants (OKAY, SLVERR), register count 4, and write/read state enums.
REQ-037 Byte-strobe merge SHALL be sub-module axi_tmp_strb_merge (old word, new word, strobe -> merged word).

Verification
REQ-038 Write 1,2,3,4 to 0x0,0x4,0x8,0xC, read back -> RDATA 1,2,3,4, all RESP=00.
REQ-039 W two cycles before AW, then AW before W -> both complete, BVALID one cycle after second handshake.
REQ-040 reg1=0xFFFFFFFF, write 0x12345678 WSTRB=0101 -> read 0xFF34FF78.
REQ-041 Write 0xDEAD to 0x14, read 0x18 -> BRESP=10, RDATA=0, RRESP=10, regs_o unchanged.
REQ-042 BREADY/RREADY low 5 cycles -> BVALID/RVALID, BRESP/RDATA held; no new AW/W/AR accepted.
REQ-043 ARESET pulsed while in W_GOT_A -> no BVALID, regs_o=0, next write completes normally.
